// File: rtl/cu_pkg.sv
// Shared definitions for the multi-cycle control unit: state encoding,
// opcode map, BRANCH and DataSel codes.
package cu_pkg;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALTED    = 3'd5,
    S_TRAP      = 3'd6
  } state_t;

  localparam logic [3:0] OP_ALU     = 4'h0;
  localparam logic [3:0] OP_ALU_IMM = 4'h1;
  localparam logic [3:0] OP_LOAD    = 4'h2;
  localparam logic [3:0] OP_STORE   = 4'h3;
  localparam logic [3:0] OP_BR      = 4'h4;
  localparam logic [3:0] OP_BMI     = 4'h5;
  localparam logic [3:0] OP_BPL     = 4'h6;
  localparam logic [3:0] OP_BZ      = 4'h7;
  localparam logic [3:0] OP_MOVE    = 4'h8;
  localparam logic [3:0] OP_CMOV    = 4'h9;
  localparam logic [3:0] OP_NOP     = 4'hE;
  localparam logic [3:0] OP_HALT    = 4'hF;

  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_BR   = 3'b001;
  localparam logic [2:0] BR_BMI  = 3'b010;
  localparam logic [2:0] BR_BPL  = 3'b011;
  localparam logic [2:0] BR_BZ   = 3'b100;

  localparam logic [1:0] DS_ALU  = 2'b00;
  localparam logic [1:0] DS_MEM  = 2'b01;
  localparam logic [1:0] DS_CMOV = 2'b10;

  function automatic logic [2:0] branch_code(input logic [3:0] op);
    case (op)
      OP_BR:   return BR_BR;
      OP_BMI:  return BR_BMI;
      OP_BPL:  return BR_BPL;
      OP_BZ:   return BR_BZ;
      default: return BR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/cu_mem_timer.sv
// Data-memory wait counter: counts MEM cycles without mem_ready and flags
// expiry once the count reaches LIMIT.
import cu_pkg::*;

module cu_mem_timer #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [7:0] LIM = 8'(LIMIT);

  logic [7:0] mcnt;

  // Saturates at LIMIT so expired stays asserted until the next clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mcnt <= '0;
    end else if (clear) begin
      mcnt <= '0;
    end else if (enable && !expired) begin
      mcnt <= mcnt + 8'd1;
    end
  end

  assign expired = (mcnt == LIM);

endmodule

// File: rtl/control_unit_mc.sv
// Multi-cycle CPU control unit (FETCH/DECODE/EXECUTE/MEM/WRITEBACK/HALTED).
// Define CU_TRAP_EN to add the TRAP state for illegal opcodes and memory timeouts.
import cu_pkg::*;

module control_unit_mc #(
  parameter int OP_W         = 4,
  parameter int FETCH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 15
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            cont,
  input  logic [OP_W-1:0] op_code,
  input  logic            mem_ready,
  output logic            loadIR,
  output logic            loadPC,
  output logic            writeReg,
  output logic            MemEn,
  output logic            MemWen,
  output logic            IMMsel,
  output logic [1:0]      DataSel,
  output logic [2:0]      BRANCH,
  output logic            halted,
  output logic            trap
);

  localparam logic [3:0] FETCH_LAST = 4'(FETCH_CYCLES - 1);

  state_t          state;
  state_t          exec_next;
  logic [3:0]      fcnt;
  logic [OP_W-1:0] op_q;
  logic            cont_q;
  logic [3:0]      op_eff;
  logic            op_illegal;
  logic            exec_en;
  logic            fetch_done;
  logic            mem_expired;
  logic            mem_drop;
  logic            resume;

  assign fetch_done = (fcnt == FETCH_LAST);
  assign resume     = cont && !cont_q;
  assign op_illegal = ((op_q >> 4) != '0) ||
                      (op_q[3:0] inside {4'hA, 4'hB, 4'hC, 4'hD});

  // Illegal opcodes collapse to NOP; with traps enabled EXECUTE suppresses
  // their outputs and diverts to TRAP instead.
  always_comb begin
    op_eff = op_q[3:0];
    if (op_illegal) op_eff = OP_NOP;
  end

`ifdef CU_TRAP_EN
  assign exec_en  = !op_illegal;
  assign mem_drop = 1'b0;
`else
  assign exec_en  = 1'b1;
  assign mem_drop = mem_expired && !mem_ready;
`endif

  cu_mem_timer #(.LIMIT(MEM_TIMEOUT)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (state != S_MEM),
    .enable  ((state == S_MEM) && !mem_ready),
    .expired (mem_expired)
  );

  always_comb begin
    case (op_eff)
      OP_LOAD, OP_STORE: exec_next = S_MEM;
      OP_HALT:           exec_next = S_HALTED;
      default:           exec_next = S_FETCH;
    endcase
`ifdef CU_TRAP_EN
    if (op_illegal) exec_next = S_TRAP;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= S_FETCH;
      fcnt   <= '0;
      op_q   <= OP_W'(OP_NOP);
      cont_q <= 1'b1;
    end else begin
      cont_q <= cont;
      fcnt   <= '0;
      case (state)
        S_FETCH: begin
          if (fetch_done) state <= S_DECODE;
          else            fcnt  <= fcnt + 4'd1;
        end
        S_DECODE: begin
          op_q  <= op_code;
          state <= S_EXECUTE;
        end
        S_EXECUTE: state <= exec_next;
        S_MEM: begin
          if (mem_ready) begin
            state <= (op_eff == OP_LOAD) ? S_WRITEBACK : S_FETCH;
          end else if (mem_expired) begin
`ifdef CU_TRAP_EN
            state <= S_TRAP;
`else
            state <= S_FETCH;
`endif
          end
        end
        S_WRITEBACK: state <= S_FETCH;
        S_HALTED: begin
          if (resume) state <= S_FETCH;
        end
`ifdef CU_TRAP_EN
        S_TRAP: state <= S_TRAP;
`endif
        default: state <= S_FETCH;
      endcase
    end
  end

  // Outputs are decoded from state and op_q and forced low while in reset.
  always_comb begin
    loadIR   = 1'b0;
    loadPC   = 1'b0;
    writeReg = 1'b0;
    MemEn    = 1'b0;
    MemWen   = 1'b0;
    IMMsel   = 1'b0;
    DataSel  = DS_ALU;
    BRANCH   = BR_NONE;
    halted   = 1'b0;
    trap     = 1'b0;
    if (reset_n) begin
      case (state)
        S_FETCH: loadIR = fetch_done;
        S_EXECUTE: begin
          if (exec_en) begin
            case (op_eff)
              OP_ALU: begin
                writeReg = 1'b1;
                loadPC   = 1'b1;
              end
              OP_ALU_IMM: begin
                writeReg = 1'b1;
                loadPC   = 1'b1;
                IMMsel   = 1'b1;
              end
              OP_LOAD: begin
                IMMsel  = 1'b1;
                DataSel = DS_MEM;
              end
              OP_STORE: IMMsel = 1'b1;
              OP_BR, OP_BMI, OP_BPL, OP_BZ: begin
                IMMsel = 1'b1;
                BRANCH = branch_code(op_eff);
                loadPC = 1'b1;
              end
              OP_MOVE: begin
                writeReg = 1'b1;
                loadPC   = 1'b1;
              end
              OP_CMOV: begin
                writeReg = 1'b1;
                DataSel  = DS_CMOV;
                loadPC   = 1'b1;
              end
              OP_HALT: loadPC = 1'b0;
              default: loadPC = 1'b1;
            endcase
          end
        end
        S_MEM: begin
          MemEn  = 1'b1;
          IMMsel = 1'b1;
          if (op_eff == OP_STORE) begin
            MemWen = 1'b1;
            loadPC = mem_ready || mem_drop;
          end else begin
            DataSel = DS_MEM;
            loadPC  = mem_drop;
          end
        end
        S_WRITEBACK: begin
          writeReg = 1'b1;
          DataSel  = DS_MEM;
          loadPC   = 1'b1;
        end
        S_HALTED: begin
          halted = 1'b1;
          loadPC = resume;
        end
`ifdef CU_TRAP_EN
        S_TRAP: trap = 1'b1;
`endif
        default: loadPC = 1'b0;
      endcase
    end
  end

endmodule
